// File: rtl/game_pkg.sv
// Shared constants and types for the 4-digit guessing game.
// Provides:
//   NUM_DIGITS, DIGIT_W, DIGIT_BLANK  digit/code geometry and the "empty" code
//   digit_t                           one digit
//   score_state_t                     scoring engine FSM states
//   digit_at()                        extracts digit idx from a packed code (idx 0 = rightmost)
package game_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned CNT_W      = 3;

  localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hA;
  localparam logic [CNT_W-1:0]   ACC_MAX     = 3'd7;
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_DIGITS - 1);

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_SCAN,
    S_DONE
  } score_state_t;

  function automatic digit_t digit_at(input logic [CODE_W-1:0] code,
                                      input logic [IDX_W-1:0]  idx);
    return code[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/ab_score_engine.sv
// Sequential A/B scoring engine. On start it snapshots Secret/Guess, compares one digit pair
// per cycle over all NUM_DIGITS*NUM_DIGITS pairs, then publishes the counts.
// Ports:
//   clk           system clock (posedge)
//   RESET_N       asynchronous active-low reset
//   clear         synchronous clear, priority over start
//   start         one-cycle scoring request, honoured only in IDLE
//   Secret/Guess  packed codes, digit 3 (leftmost) in the top nibble
//   busy          high from SNAP through SCAN
//   done          one-cycle pulse when counts update
//   result_valid  counts valid; held until clear or next accepted start
//   Count_A       right digit, right place
//   Count_B       right digit, wrong place
//   win           result_valid && Count_A == NUM_DIGITS
module ab_score_engine
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              clear,
  input  logic              start,
  input  logic [CODE_W-1:0] Secret,
  input  logic [CODE_W-1:0] Guess,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [CNT_W-1:0]  Count_A,
  output logic [CNT_W-1:0]  Count_B,
  output logic              win
);

  score_state_t      state_q;
  logic [CODE_W-1:0] sec_q, gss_q;
  logic [IDX_W-1:0]  i_q, j_q;
  logic [CNT_W-1:0]  acc_a_q, acc_b_q;
  logic [CNT_W-1:0]  count_a_q, count_b_q;
  logic              busy_q, done_q, valid_q;

  digit_t           s_dig, g_dig;
  logic             match, last_pair;
  logic [CNT_W-1:0] acc_a_d, acc_b_d;
  logic [IDX_W-1:0] i_d, j_d;

  always_comb begin
    s_dig     = digit_at(sec_q, i_q);
    g_dig     = digit_at(gss_q, j_q);
    match     = (s_dig == g_dig) && (s_dig != DIGIT_BLANK) && (g_dig != DIGIT_BLANK);
    last_pair = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    if (match && (i_q == j_q) && (acc_a_q != ACC_MAX)) acc_a_d = acc_a_q + 3'd1;
    if (match && (i_q != j_q) && (acc_b_q != ACC_MAX)) acc_b_d = acc_b_q + 3'd1;
    // j runs fastest: {i,j} behaves as one pair counter.
    {i_d, j_d} = {i_q, j_q} + {{IDX_W{1'b0}}, {(IDX_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      sec_q     <= '0;
      gss_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      count_a_q <= '0;
      count_b_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      sec_q     <= '0;
      gss_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      count_a_q <= '0;
      count_b_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SNAP;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        S_SNAP: begin
          sec_q   <= Secret;
          gss_q   <= Guess;
          acc_a_q <= '0;
          acc_b_q <= '0;
          i_q     <= '0;
          j_q     <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          acc_a_q <= acc_a_d;
          acc_b_q <= acc_b_d;
          i_q     <= i_d;
          j_q     <= j_d;
          // Publish on the last compare so counts and done appear together in DONE.
          if (last_pair) begin
            count_a_q <= acc_a_d;
            count_b_q <= acc_b_d;
            valid_q   <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign Count_A      = count_a_q;
  assign Count_B      = count_b_q;
  assign win          = valid_q && (count_a_q == CNT_W'(NUM_DIGITS));

endmodule

// File: tb/tb_ab_score_engine.sv
// Self-checking bench for ab_score_engine: directed scenarios plus randomized codes checked
// against a pair-counting reference model.
module tb_ab_score_engine;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] Secret = '0;
  logic [15:0] Guess = '0;
  logic        busy, done, result_valid, win;
  logic [2:0]  Count_A, Count_B;

  int n_checks = 0;
  int n_fail   = 0;

  ab_score_engine dut (
    .clk          (clk),
    .RESET_N      (RESET_N),
    .clear        (clear),
    .start        (start),
    .Secret       (Secret),
    .Guess        (Guess),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .Count_A      (Count_A),
    .Count_B      (Count_B),
    .win          (win)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count every matching non-blank digit pair, then saturate at 7.
  function automatic void model(input logic [15:0] s, input logic [15:0] g,
                                output int a, output int b);
    logic [3:0] si, gj;
    a = 0;
    b = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        si = s[i*4 +: 4];
        gj = g[j*4 +: 4];
        if (si == gj && si != 4'hA && gj != 4'hA) begin
          if (i == j) a++;
          else b++;
        end
      end
    end
    if (a > 7) a = 7;
    if (b > 7) b = 7;
  endfunction

  // Pulse start for one edge, then count cycles until done (bounded).
  task automatic run_op(input logic [15:0] s, input logic [15:0] g, output int lat);
    Secret = s;
    Guess  = g;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, result_valid, Count_A, Count_B, win} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b rv=%b A=%0d B=%0d win=%b, want all 0",
               busy, done, result_valid, Count_A, Count_B, win);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_exact();
    int lat;
    Secret = 16'h1234;
    Guess  = 16'h1234;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_busy: got busy=%b rv=%b, want busy=1 rv=0", busy, result_valid);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL exact_latency: got %0d cycles after start edge, want 17", lat);
    end
    n_checks++;
    if (Count_A !== 3'd4 || Count_B !== 3'd0 || win !== 1'b1 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL exact_counts: got A=%0d B=%0d win=%b rv=%b, want A=4 B=0 win=1 rv=1",
               Count_A, Count_B, win, result_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || result_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_after: got done=%b rv=%b busy=%b, want done=0 rv=1 busy=0",
               done, result_valid, busy);
    end
  endtask

  task automatic test_reverse();
    int lat;
    run_op(16'h1234, 16'h4321, lat);
    n_checks++;
    if (lat !== 17 || Count_A !== 3'd0 || Count_B !== 3'd4 || win !== 1'b0) begin
      n_fail++;
      $display("FAIL reverse: got lat=%0d A=%0d B=%0d win=%b, want lat=17 A=0 B=4 win=0",
               lat, Count_A, Count_B, win);
    end
    tick();
  endtask

  task automatic test_blank();
    int lat;
    run_op(16'h5678, 16'h5A7A, lat);
    n_checks++;
    if (lat !== 17 || Count_A !== 3'd2 || Count_B !== 3'd0) begin
      n_fail++;
      $display("FAIL blank_partial: got lat=%0d A=%0d B=%0d, want lat=17 A=2 B=0",
               lat, Count_A, Count_B);
    end
    tick();
    run_op(16'hAAAA, 16'hAAAA, lat);
    n_checks++;
    if (Count_A !== 3'd0 || Count_B !== 3'd0 || win !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_all: got A=%0d B=%0d win=%b, want A=0 B=0 win=0",
               Count_A, Count_B, win);
    end
    tick();
    // Duplicates: 4 exact plus 12 cross pairs, B saturates.
    run_op(16'h1111, 16'h1111, lat);
    n_checks++;
    if (Count_A !== 3'd4 || Count_B !== 3'd7) begin
      n_fail++;
      $display("FAIL dup_saturate: got A=%0d B=%0d, want A=4 B=7", Count_A, Count_B);
    end
    tick();
  endtask

  task automatic test_snapshot();
    int dones = 0;
    Secret = 16'h1234;
    Guess  = 16'h4321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    // Change operands mid-scan and retry start while busy.
    Guess  = 16'h1234;
    Secret = 16'h9999;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        dones++;
        n_checks++;
        if (Count_A !== 3'd0 || Count_B !== 3'd4) begin
          n_fail++;
          $display("FAIL snapshot_counts: got A=%0d B=%0d, want A=0 B=4", Count_A, Count_B);
        end
      end
      tick();
    end
    n_checks++;
    if (dones !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL snapshot_pulses: got %0d done pulses busy=%b, want 1 busy=0", dones, busy);
    end
  endtask

  task automatic test_clear();
    int lat;
    run_op(16'h1234, 16'h1234, lat);
    tick();
    Secret = 16'h5678;
    Guess  = 16'h5678;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_drops_valid: got rv=%b, want 0", result_valid);
    end
    tick();                          // now in first SCAN cycle
    for (int n = 0; n < 7; n++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Count_A !== 3'd0 || Count_B !== 3'd0 ||
        result_valid !== 1'b0 || win !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_abort: got busy=%b done=%b A=%0d B=%0d rv=%b win=%b, want all 0",
               busy, done, Count_A, Count_B, result_valid, win);
    end
    lat = 0;
    for (int n = 0; n < 25; n++) begin
      if (done) lat++;
      tick();
    end
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL clear_no_done: got %0d done pulses, want 0", lat);
    end
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_beats_start: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    run_op(16'h1234, 16'h1234, lat);
    tick();
    Secret = 16'h1234;
    Guess  = 16'h1234;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    #3;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result_valid, Count_A, Count_B, win} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset_now: got busy=%b done=%b rv=%b A=%0d B=%0d win=%b, want 0",
               busy, done, result_valid, Count_A, Count_B, win);
    end
    tick();
    tick();
    n_checks++;
    if ({busy, done, result_valid, Count_A, Count_B, win} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset_held: got busy=%b done=%b rv=%b A=%0d B=%0d win=%b, want 0",
               busy, done, result_valid, Count_A, Count_B, win);
    end
    RESET_N = 1'b1;
    tick();
    run_op(16'h0987, 16'h7890, lat);
    n_checks++;
    if (lat !== 17 || Count_A !== 3'd0 || Count_B !== 3'd4 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_op: got lat=%0d A=%0d B=%0d rv=%b, want lat=17 A=0 B=4 rv=1",
               lat, Count_A, Count_B, result_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, ea, eb;
    logic [15:0] s, g;
    // Start in DONE is dropped.
    run_op(16'h2468, 16'h8642, lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: got busy=%b, want 0", busy);
    end
    // Random codes, each start issued in the first cycle it can be accepted.
    for (int t = 0; t < 24; t++) begin
      for (int d = 0; d < 4; d++) begin
        s[d*4 +: 4] = 4'($urandom_range(0, 10));
        g[d*4 +: 4] = 4'($urandom_range(0, 10));
      end
      if (t % 4 == 0) g = s;
      model(s, g, ea, eb);
      run_op(s, g, lat);
      n_checks++;
      if (lat !== 17 || Count_A !== 3'(ea) || Count_B !== 3'(eb) ||
          win !== (ea == 4) || result_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL random_%0d: S=%h G=%h got lat=%0d A=%0d B=%0d win=%b, want 17 %0d %0d %b",
                 t, s, g, lat, Count_A, Count_B, win, ea, eb, (ea == 4));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_reverse();
    test_blank();
    test_snapshot();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
